// File: rtl/pe_sm_adder_tree_acc.sv
// Pipelined reduction of LANES sign-magnitude operands into a two's-complement sum,
// followed by a framed, optionally saturating accumulator with valid/ready flow control.
module pe_sm_adder_tree_acc #(
   parameter int unsigned SIZE  = 4,
   parameter int unsigned LANES = 8,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned SAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*SIZE-1:0] in_mag,
   input  logic [LANES-1:0]      in_sign,
   input  logic                  in_first,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic                  out_ovf,
   output logic                  frame_abort
);

   localparam int unsigned LG    = $clog2(LANES);
   localparam int unsigned SUM_W = SIZE + 1 + LG;
   localparam int unsigned EXT_W = ACC_W + 1;

   typedef enum logic {ST_IDLE, ST_ACC} state_t;

   logic                    stall;
   logic signed [SIZE:0]    lane_val [LANES];
   logic [LG-1:0]           vld_q;
   logic [LG-1:0]           first_q;
   logic [LG-1:0]           last_q;
   logic signed [SUM_W-1:0] tree_sum;

   // A result waiting on downstream freezes every stage behind it.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         lane_val[k] = in_sign[k] ? -$signed({1'b0, in_mag[k*SIZE +: SIZE]})
                                  :  $signed({1'b0, in_mag[k*SIZE +: SIZE]});
      end
   end

   // Beat sideband travels alongside the tree levels.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else if (!stall) begin
         vld_q[0] <= in_valid;
         for (int l = 1; l < LG; l++) vld_q[l] <= vld_q[l-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!stall) begin
         first_q[0] <= in_first;
         last_q[0]  <= in_last;
         for (int l = 1; l < LG; l++) begin
            first_q[l] <= first_q[l-1];
            last_q[l]  <= last_q[l-1];
         end
      end
   end

   // Level l holds LANES>>(l+1) partial sums, each one bit wider than the level before.
   for (genvar l = 0; l < LG; l++) begin : g_lvl
      localparam int unsigned W = SIZE + 2 + l;
      localparam int unsigned N = LANES >> (l + 1);
      logic signed [W-1:0] sum_q [N];

      if (l == 0) begin : g_leaf
         always_ff @(posedge clk) begin
            if (!stall) begin
               for (int i = 0; i < N; i++)
                  sum_q[i] <= W'(lane_val[2*i]) + W'(lane_val[2*i+1]);
            end
         end
      end else begin : g_node
         always_ff @(posedge clk) begin
            if (!stall) begin
               for (int i = 0; i < N; i++)
                  sum_q[i] <= W'(g_lvl[l-1].sum_q[2*i]) + W'(g_lvl[l-1].sum_q[2*i+1]);
            end
         end
      end
   end

   assign tree_sum = g_lvl[LG-1].sum_q[0];

   logic                    tail_valid;
   logic                    tail_first;
   logic                    tail_last;
   logic                    fire;
   state_t                  state_q;
   state_t                  state_d;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic                    ovf_q;
   logic                    ovf_d;
   logic                    out_valid_d;
   logic [ACC_W-1:0]        out_data_d;
   logic                    out_ovf_d;
   logic                    abort_d;
   logic signed [EXT_W-1:0] base;
   logic signed [EXT_W-1:0] res;
   logic signed [ACC_W-1:0] clipped;
   logic                    step_ovf;
   logic                    frame_ovf;

   assign tail_valid = vld_q[LG-1];
   assign tail_first = first_q[LG-1];
   assign tail_last  = last_q[LG-1];
   assign fire       = tail_valid & ~stall;

   // Accumulate stage and frame tracking.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      out_ovf_d   = out_ovf;
      abort_d     = 1'b0;

      base     = tail_first ? '0 : EXT_W'(acc_q);
      res      = base + EXT_W'(tree_sum);
      step_ovf = res[ACC_W] ^ res[ACC_W-1];
      clipped  = res[ACC_W-1:0];
      if (step_ovf && SAT != 0)
         clipped = res[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      frame_ovf = step_ovf | (ovf_q & ~tail_first);

      if (out_valid && out_ready) out_valid_d = 1'b0;

      if (fire) begin
         abort_d = tail_first & (state_q == ST_ACC);
         if (tail_last) begin
            out_valid_d = 1'b1;
            out_data_d  = clipped;
            out_ovf_d   = frame_ovf;
            acc_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ST_IDLE;
         end else begin
            acc_d   = clipped;
            ovf_d   = frame_ovf;
            state_d = ST_ACC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_ovf     <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         out_valid   <= out_valid_d;
         out_data    <= out_data_d;
         out_ovf     <= out_ovf_d;
         frame_abort <= abort_d;
      end
   end

endmodule

// File: tb/tb_pe_sm_adder_tree_acc.sv
// Bench for pe_sm_adder_tree_acc: integer frame model checked every cycle plus directed literal cases.
module tb_pe_sm_adder_tree_acc;

   localparam int unsigned SIZE  = 4;
   localparam int unsigned LANES = 8;
   localparam int MAXV = 32767;
   localparam int MINV = -32768;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_first, in_last, out_ready, sm_valid;
   logic [31:0] in_mag;
   logic [7:0]  in_sign;
   logic        in_ready, out_valid, out_ovf, frame_abort;
   logic [15:0] out_data;
   logic        sat_in_ready, sat_out_valid, sat_out_ovf, sat_abort;
   logic [7:0]  sat_out_data;
   logic        wrap_in_ready, wrap_out_valid, wrap_out_ovf, wrap_abort;
   logic [7:0]  wrap_out_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pe_sm_adder_tree_acc #(.SIZE(4), .LANES(8), .ACC_W(16), .SAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mag(in_mag), .in_sign(in_sign), .in_first(in_first), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ovf(out_ovf), .frame_abort(frame_abort));

   pe_sm_adder_tree_acc #(.SIZE(4), .LANES(8), .ACC_W(8), .SAT(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(sm_valid), .in_ready(sat_in_ready),
      .in_mag(in_mag), .in_sign(in_sign), .in_first(in_first), .in_last(in_last),
      .out_valid(sat_out_valid), .out_ready(1'b1), .out_data(sat_out_data),
      .out_ovf(sat_out_ovf), .frame_abort(sat_abort));

   pe_sm_adder_tree_acc #(.SIZE(4), .LANES(8), .ACC_W(8), .SAT(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(sm_valid), .in_ready(wrap_in_ready),
      .in_mag(in_mag), .in_sign(in_sign), .in_first(in_first), .in_last(in_last),
      .out_valid(wrap_out_valid), .out_ready(1'b1), .out_data(wrap_out_data),
      .out_ovf(wrap_out_ovf), .frame_abort(wrap_abort));

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame model: plain integer sums per accepted beat, results queued in order.
   int  exp_q[$];
   bit  expo_q[$];
   int  m_acc = 0;
   bit  m_ovf = 1'b0;
   bit  m_open = 1'b0;
   int  exp_aborts = 0;
   int  obs_aborts = 0;
   logic        p_rst_n = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_ovf = 1'b0;
   logic [15:0] p_data = '0;
   int  s, r, mg, e;
   bit  ov, eo;

   always @(negedge clk) begin
      if (!p_rst_n) begin
         check("reset_out_valid", int'(out_valid), 0);
         check("reset_out_data", int'(out_data), 0);
         check("reset_out_ovf", int'(out_ovf), 0);
         check("reset_frame_abort", int'(frame_abort), 0);
      end else if (p_valid && !p_ready) begin
         check("hold_valid", int'(out_valid), 1);
         check("hold_data", int'(out_data), int'(p_data));
         check("hold_ovf", int'(out_ovf), int'(p_ovf));
      end else if (out_valid) begin
         check("pending_result", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            eo = expo_q.pop_front();
            check("model_data", int'(out_data), e & 'hFFFF);
            check("model_ovf", int'(out_ovf), int'(eo));
         end
      end
      check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (frame_abort) obs_aborts++;

      if (!rst_n) begin
         exp_q.delete();
         expo_q.delete();
         m_acc = 0; m_ovf = 1'b0; m_open = 1'b0;
      end else if (in_valid && in_ready) begin
         s = 0;
         for (int k = 0; k < LANES; k++) begin
            mg = int'(in_mag[k*SIZE +: SIZE]);
            s  = in_sign[k] ? s - mg : s + mg;
         end
         if (in_first) begin
            if (m_open) exp_aborts++;
            r = s; ov = 1'b0;
         end else begin
            r = m_acc + s; ov = m_ovf;
         end
         if (r > MAXV) begin r = MAXV; ov = 1'b1; end
         else if (r < MINV) begin r = MINV; ov = 1'b1; end
         if (in_last) begin
            exp_q.push_back(r); expo_q.push_back(ov);
            m_acc = 0; m_ovf = 1'b0; m_open = 1'b0;
         end else begin
            m_acc = r; m_ovf = ov; m_open = 1'b1;
         end
      end
      p_rst_n = rst_n; p_valid = out_valid; p_ready = out_ready;
      p_data = out_data; p_ovf = out_ovf;
   end

   // Call at posedge+1; returns at posedge+1 after the beat has been accepted.
   task automatic send(input logic [31:0] m, input logic [7:0] sg, input logic f, input logic l);
      int guard;
      guard = 0;
      in_valid = 1'b1; in_mag = m; in_sign = sg; in_first = f; in_last = l;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready still 0 after %0d cycles", guard);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_result(output logic [15:0] d, output logic o, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 40);
      if (!out_valid) begin
         n_cmp++; n_bad++;
         $display("FAIL result_timeout: out_valid still 0 after %0d cycles", cyc);
      end
      d = out_data;
      o = out_ovf;
   endtask

   task automatic align();
      @(posedge clk); #1;
   endtask

   logic [15:0] d;
   logic        o;
   int          cyc, tot, abase, cnt;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; sm_valid = 1'b0; in_mag = '0; in_sign = '0;
      in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_out_valid", int'(out_valid), 0);
      check("post_reset_in_ready", int'(in_ready), 1);
      check("post_reset_out_data", int'(out_data), 0);
      align();

      // Single-beat frame: latency and positive full-scale sum.
      send(32'hFFFF_FFFF, 8'h00, 1'b1, 1'b1);
      wait_result(d, o, cyc);
      check("t1_latency", cyc, 4);
      check("t1_data", int'(d), 120);
      check("t1_ovf", int'(o), 0);
      align();

      // Alternating signs, then all negative zeros.
      send(32'h8765_4321, 8'hAA, 1'b1, 1'b1);
      wait_result(d, o, cyc);
      check("t2_mixed", int'(d), 'hFFFC);
      align();
      send(32'h0000_0000, 8'hFF, 1'b1, 1'b1);
      wait_result(d, o, cyc);
      check("t2_negzero", int'(d), 0);
      align();

      // Back-to-back frames.
      send(32'hFFFF_FFFF, 8'h00, 1'b1, 1'b0);
      send(32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1);
      send(32'h1111_1111, 8'h00, 1'b1, 1'b1);
      wait_result(d, o, cyc);
      check("t3_frame3", int'(d), 360);
      wait_result(d, o, cyc);
      check("t3_next_frame", int'(d), 8);
      check("t3_next_gap", cyc, 1);
      align();

      // Narrow accumulator: saturate vs wrap.
      in_mag = 32'hFFFF_FFFF; in_sign = 8'h00; in_first = 1'b1; in_last = 1'b0; sm_valid = 1'b1;
      check("t4_sat_ready", int'(sat_in_ready), 1);
      check("t4_wrap_ready", int'(wrap_in_ready), 1);
      align();
      in_first = 1'b0; in_last = 1'b1;
      align();
      sm_valid = 1'b0; in_last = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!sat_out_valid && cyc < 20);
      check("t4_sat_valid", int'(sat_out_valid), 1);
      check("t4_wrap_valid", int'(wrap_out_valid), 1);
      check("t4_sat_data", int'(sat_out_data), 127);
      check("t4_sat_ovf", int'(sat_out_ovf), 1);
      check("t4_wrap_data", int'(wrap_out_data), 'hF0);
      check("t4_wrap_ovf", int'(wrap_out_ovf), 1);
      align();

      // Output stall with a continuous input stream.
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               send({8{4'(i + 1)}}, 8'h00, 1'b1, 1'b0);
               send({8{4'd2}}, 8'h00, 1'b0, 1'b1);
            end
         end
         begin
            wait_result(d, o, cyc);
            check("t5_frame0", int'(d), 24);
            for (int c = 0; c < 5; c++) begin
               if (c > 0) @(negedge clk);
               check("t5_stall_in_ready", int'(in_ready), 0);
               check("t5_stall_data", int'(out_data), 24);
            end
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk);
            tot = 0;
            for (int f = 0; f < 4; f++) begin
               wait_result(d, o, cyc);
               tot += int'(d);
            end
            check("t5_sum4", tot, 176);
         end
      join
      align();

      // First mid-frame restarts the frame.
      abase = obs_aborts;
      send({8{4'd3}}, 8'h00, 1'b1, 1'b0);
      send({8{4'd1}}, 8'h00, 1'b0, 1'b0);
      send({8{4'd2}}, 8'h00, 1'b1, 1'b0);
      send({8{4'd1}}, 8'h00, 1'b0, 1'b1);
      wait_result(d, o, cyc);
      check("t6_abort_data", int'(d), 24);
      check("t6_abort_pulses", obs_aborts - abase, 1);
      align();

      // Reset with a frame in flight drops it.
      send({8{4'd1}}, 8'h00, 1'b1, 1'b0);
      send({8{4'd1}}, 8'h00, 1'b0, 1'b1);
      rst_n = 1'b0;
      align();
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_rst_out_valid", int'(out_valid), 0);
      check("t6_rst_out_data", int'(out_data), 0);
      check("t6_rst_out_ovf", int'(out_ovf), 0);
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("t6_no_result", cnt, 0);
      align();

      // Beats without first after reset accumulate from zero.
      send({8{4'd1}}, 8'h00, 1'b0, 1'b0);
      send({8{4'd2}}, 8'h00, 1'b0, 1'b1);
      wait_result(d, o, cyc);
      check("t7_no_first", int'(d), 24);
      align();

      repeat (10) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("abort_total", obs_aborts, exp_aborts);
      check("narrow_no_abort", int'(sat_abort | wrap_abort), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete (%0d compared, %0d mismatched)", n_cmp, n_bad);
      $fatal(1);
   end

endmodule
